// File: rtl/noc_pkg.sv
// Shared NoC definitions: port indices, select encoding and allocator state type.
package noc_pkg;

  localparam int NUM_PORTS = 5;
  localparam int P_NORTH   = 4;
  localparam int P_EAST    = 3;
  localparam int P_WEST    = 2;
  localparam int P_SOUTH   = 1;
  localparam int P_LOCAL   = 0;

  localparam logic [2:0] SEL_NONE = 3'b111;

  typedef enum logic {
    ALLOC_IDLE,
    ALLOC_LOCKED
  } alloc_state_t;

  // Port index successor, wrapping 4 -> 0.
  function automatic logic [2:0] next_port(input logic [2:0] idx);
    return (idx >= 3'd4) ? 3'd0 : idx + 3'd1;
  endfunction

  // Bit select with a 3-bit index; indices 5..7 read as zero.
  function automatic logic port_bit(input logic [4:0] vec, input logic [2:0] idx);
    logic [7:0] ext;
    ext = {3'b000, vec};
    return ext[idx];
  endfunction

endpackage

// File: rtl/rr_arbiter_5.sv
// Five-way round-robin pick: first set request at or after the pointer, wrapping.
module rr_arbiter_5
  import noc_pkg::*;
(
  input  logic [4:0] req,
  input  logic [2:0] ptr,
  output logic [2:0] winner,
  output logic       any_grant
);

  logic [2:0] idx;

  // NOTE: every combinational output gets a default before the scan so no latch is inferred.
  always_comb begin
    winner    = '0;
    any_grant = 1'b0;
    idx       = ptr;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (!any_grant && port_bit(req, idx)) begin
        winner    = idx;
        any_grant = 1'b1;
      end
      idx = next_port(idx);
    end
  end

endmodule

// File: rtl/switch_allocator.sv
// Per-output round-robin switch allocator with wormhole locking, credit gating and a lock watchdog.
module switch_allocator
  import noc_pkg::*;
#(
  parameter int CREDIT_W = 3,
  parameter int TIMEOUT  = 16,
  parameter int TO_W     = $clog2(TIMEOUT + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [24:0]               req_i,
  input  logic [4:0]                head_i,
  input  logic [4:0]                tail_i,
  input  logic [5*CREDIT_W-1:0]     credit_all_i,
  output logic [14:0]               sel_o,
  output logic [4:0]                send_o,
  output logic [4:0]                credit_dec_o,
  output logic [4:0]                locked_o,
  output logic [4:0]                timeout_o,
  output logic                      error_o
);

  alloc_state_t    state_q [NUM_PORTS];
  alloc_state_t    state_d [NUM_PORTS];
  logic [2:0]      owner_q [NUM_PORTS];
  logic [2:0]      owner_d [NUM_PORTS];
  logic [2:0]      rr_ptr_q[NUM_PORTS];
  logic [2:0]      rr_ptr_d[NUM_PORTS];
  logic [TO_W-1:0] wd_q    [NUM_PORTS];
  logic [TO_W-1:0] wd_d    [NUM_PORTS];
  logic [4:0]      timeout_q, timeout_d;
  logic            error_q;

  logic [4:0]      valid, multi_hot;
  logic [4:0]      req_p   [NUM_PORTS];
  logic [4:0]      cand    [NUM_PORTS];
  logic [2:0]      win     [NUM_PORTS];
  logic [4:0]      any_win;
  logic [2:0]      sel     [NUM_PORTS];
  logic [4:0]      send_vec, dec_vec;
  logic            proto_err;
  logic            credit_ok;
  logic [2:0]      own;

  // Transpose input requests into per-output request vectors, dropping multi-hot inputs.
  always_comb begin
    valid     = '0;
    multi_hot = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      valid[i]     = $onehot(req_i[5*i +: 5]);
      multi_hot[i] = (|req_i[5*i +: 5]) && !valid[i];
    end
    for (int p = 0; p < NUM_PORTS; p++) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        req_p[p][i] = valid[i] && req_i[5*i + p];
      end
    end
  end

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_arb
    assign cand[p] = req_p[p] & head_i;
    rr_arbiter_5 u_arb (
      .req       (cand[p]),
      .ptr       (rr_ptr_q[p]),
      .winner    (win[p]),
      .any_grant (any_win[p])
    );
  end

  always_comb begin
    send_vec  = '0;
    dec_vec   = '0;
    proto_err = 1'b0;
    timeout_d = '0;
    credit_ok = 1'b0;
    own       = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      state_d[p]  = state_q[p];
      owner_d[p]  = owner_q[p];
      rr_ptr_d[p] = rr_ptr_q[p];
      wd_d[p]     = wd_q[p];
      sel[p]      = SEL_NONE;
      credit_ok   = |credit_all_i[CREDIT_W*p +: CREDIT_W];
      own         = owner_q[p];
      case (state_q[p])
        ALLOC_IDLE: begin
          if (|(req_p[p] & ~head_i)) proto_err = 1'b1;
          if (any_win[p] && credit_ok) begin
            sel[p]      = win[p];
            send_vec    = send_vec | (5'b00001 << win[p]);
            dec_vec[p]  = 1'b1;
            rr_ptr_d[p] = next_port(win[p]);
            if (!port_bit(tail_i, win[p])) begin
              state_d[p] = ALLOC_LOCKED;
              owner_d[p] = win[p];
              wd_d[p]    = '0;
            end
          end
        end
        ALLOC_LOCKED: begin
          if (port_bit(req_p[p], own) && credit_ok) begin
            sel[p]     = own;
            send_vec   = send_vec | (5'b00001 << own);
            dec_vec[p] = 1'b1;
            wd_d[p]    = '0;
            if (port_bit(head_i, own)) proto_err = 1'b1;
            if (port_bit(tail_i, own)) state_d[p] = ALLOC_IDLE;
          end else if (wd_q[p] == TO_W'(TIMEOUT - 1)) begin
            // Owner went silent too long: drop the lock so waiting heads can proceed.
            state_d[p]   = ALLOC_IDLE;
            wd_d[p]      = '0;
            timeout_d[p] = 1'b1;
          end else begin
            wd_d[p] = wd_q[p] + TO_W'(1);
          end
        end
        default: state_d[p] = ALLOC_IDLE;
      endcase
    end
  end

  // Grant-side outputs are combinational, so they are forced quiet while reset is held.
  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      sel_o[3*p +: 3] = rst ? SEL_NONE : sel[p];
      locked_o[p]     = (state_q[p] == ALLOC_LOCKED);
    end
  end

  assign send_o       = rst ? 5'b0 : send_vec;
  assign credit_dec_o = rst ? 5'b0 : dec_vec;
  assign timeout_o    = timeout_q;
  assign error_o      = error_q;

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  // NOTE: the per-output arrays are control state, not storage, so each entry is reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        state_q[p]  <= ALLOC_IDLE;
        owner_q[p]  <= '0;
        rr_ptr_q[p] <= '0;
        wd_q[p]     <= '0;
      end
      timeout_q <= '0;
      error_q   <= 1'b0;
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        state_q[p]  <= state_d[p];
        owner_q[p]  <= owner_d[p];
        rr_ptr_q[p] <= rr_ptr_d[p];
        wd_q[p]     <= wd_d[p];
      end
      timeout_q <= timeout_d;
      error_q   <= error_q | (|multi_hot) | proto_err;
    end
  end

endmodule

// File: tb/tb_switch_allocator.sv
// Self-checking bench for switch_allocator: directed scenarios then random traffic against a reference model.
module tb_switch_allocator;
  import noc_pkg::*;

  localparam int CREDIT_W = 3;
  localparam int TIMEOUT  = 16;

  logic        clk;
  logic        rst;
  logic [24:0] req_i;
  logic [4:0]  head_i, tail_i;
  logic [14:0] credit_all_i;
  logic [14:0] sel_o;
  logic [4:0]  send_o, credit_dec_o, locked_o, timeout_o;
  logic        error_o;

  int checks = 0;
  int errors = 0;

  switch_allocator #(.CREDIT_W(CREDIT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_i        (req_i),
    .head_i       (head_i),
    .tail_i       (tail_i),
    .credit_all_i (credit_all_i),
    .sel_o        (sel_o),
    .send_o       (send_o),
    .credit_dec_o (credit_dec_o),
    .locked_o     (locked_o),
    .timeout_o    (timeout_o),
    .error_o      (error_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: per output a lock flag, owner, pointer and idle count.
  bit m_locked[5], n_locked[5], m_to[5], n_to[5];
  int m_owner[5], n_owner[5], m_ptr[5], n_ptr[5], m_wd[5], n_wd[5];
  bit m_err, n_err;
  logic [14:0] e_sel;
  logic [4:0]  e_send, e_dec, e_locked, e_to;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int p = 0; p < 5; p++) begin
      m_locked[p] = 0; m_to[p] = 0; m_owner[p] = 0; m_ptr[p] = 0; m_wd[p] = 0;
    end
    m_err = 0;
  endtask

  task automatic model_eval();
    int target[5];
    logic [4:0] slice;
    int win, o;
    bit cr;
    n_err = m_err;
    e_sel = '1; e_send = '0; e_dec = '0;
    for (int i = 0; i < 5; i++) begin
      slice = req_i[5*i +: 5];
      target[i] = -1;
      if ($countones(slice) == 1) begin
        for (int q = 0; q < 5; q++) if (slice[q]) target[i] = q;
      end else if ($countones(slice) > 1) n_err = 1;
    end
    for (int p = 0; p < 5; p++) begin
      n_locked[p] = m_locked[p]; n_owner[p] = m_owner[p];
      n_ptr[p] = m_ptr[p]; n_wd[p] = m_wd[p]; n_to[p] = 0;
      cr = (credit_all_i[3*p +: 3] != 0);
      win = -1;
      if (!m_locked[p]) begin
        for (int i = 0; i < 5; i++) if (target[i] == p && !head_i[i]) n_err = 1;
        for (int k = 0; k < 5; k++) begin
          o = (m_ptr[p] + k) % 5;
          if (win < 0 && target[o] == p && head_i[o]) win = o;
        end
        if (win >= 0 && cr) begin
          n_ptr[p] = (win + 1) % 5;
          if (!tail_i[win]) begin n_locked[p] = 1; n_owner[p] = win; n_wd[p] = 0; end
        end else win = -1;
      end else begin
        o = m_owner[p];
        if (target[o] == p && cr) begin
          win = o; n_wd[p] = 0;
          if (head_i[o]) n_err = 1;
          if (tail_i[o]) n_locked[p] = 0;
        end else if (m_wd[p] == TIMEOUT - 1) begin
          n_locked[p] = 0; n_to[p] = 1; n_wd[p] = 0;
        end else n_wd[p] = m_wd[p] + 1;
      end
      if (win >= 0) begin
        e_sel[3*p +: 3] = 3'(win);
        e_send[win] = 1'b1;
        e_dec[p] = 1'b1;
      end
      e_locked[p] = m_locked[p];
      e_to[p] = m_to[p];
    end
  endtask

  task automatic model_commit();
    for (int p = 0; p < 5; p++) begin
      m_locked[p] = n_locked[p]; m_owner[p] = n_owner[p];
      m_ptr[p] = n_ptr[p]; m_wd[p] = n_wd[p]; m_to[p] = n_to[p];
    end
    m_err = n_err;
  endtask

  // Predict from current inputs, then compare at the falling edge.
  task automatic cyc_check(input string tag);
    model_eval();
    @(negedge clk);
    chk({tag, " sel"}, 32'(sel_o), 32'(e_sel));
    chk({tag, " send"}, 32'(send_o), 32'(e_send));
    chk({tag, " dec"}, 32'(credit_dec_o), 32'(e_dec));
    chk({tag, " locked"}, 32'(locked_o), 32'(e_locked));
    chk({tag, " timeout"}, 32'(timeout_o), 32'(e_to));
    chk({tag, " error"}, 32'(error_o), 32'(m_err));
  endtask

  task automatic adv();
    @(posedge clk);
    model_commit();
    #1;
  endtask

  task automatic clear_in();
    req_i = '0; head_i = '0; tail_i = '0;
  endtask

  task automatic flit(input int i, input int p, input bit h, input bit t);
    req_i[5*i +: 5] = 5'b00001 << p;
    head_i[i] = h;
    tail_i[i] = t;
  endtask

  initial begin
    int order[6];
    logic [4:0] slice;
    rst = 1'b1;
    clear_in();
    credit_all_i = {5{3'd7}};
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    cyc_check("reset");
    chk("reset sel none", 32'(sel_o), 32'h7fff);
    adv();
    rst = 1'b0;

    // Single-flit packet local -> north.
    credit_all_i = {5{3'd3}};
    flit(P_LOCAL, P_NORTH, 1, 1);
    cyc_check("single");
    chk("single sel north", 32'(sel_o[14:12]), 32'd0);
    chk("single send", 32'(send_o), 32'b00001);
    chk("single dec", 32'(credit_dec_o), 32'b10000);
    adv();
    clear_in();
    cyc_check("single after");
    chk("single no lock", 32'(locked_o), 32'd0);
    adv();

    // Round-robin among inputs 1,2,3 to east.
    credit_all_i = {5{3'd7}};
    order = '{1, 2, 3, 1, 2, 3};
    for (int k = 0; k < 6; k++) begin
      clear_in();
      flit(1, P_EAST, 1, 1); flit(2, P_EAST, 1, 1); flit(3, P_EAST, 1, 1);
      cyc_check("rr");
      chk("rr order", 32'(send_o), 32'(5'b00001 << order[k]));
      adv();
    end
    clear_in();

    // Wormhole: north holds local for a 4-flit packet while west waits.
    flit(P_NORTH, P_LOCAL, 1, 0);
    cyc_check("worm head");
    chk("worm head send", 32'(send_o), 32'b10000);
    adv();
    for (int k = 1; k < 4; k++) begin
      flit(P_NORTH, P_LOCAL, 0, k == 3);
      flit(P_WEST, P_LOCAL, 1, 1);
      cyc_check("worm body");
      chk("worm west blocked", 32'(send_o[P_WEST]), 32'd0);
      chk("worm locked", 32'(locked_o[P_LOCAL]), 32'd1);
      adv();
    end
    clear_in();
    flit(P_WEST, P_LOCAL, 1, 1);
    cyc_check("worm release");
    chk("worm unlocked", 32'(locked_o[P_LOCAL]), 32'd0);
    chk("worm west granted", 32'(send_o), 32'b00100);
    adv();
    clear_in();

    // Credit stall on a locked east output.
    flit(P_WEST, P_EAST, 1, 0);
    cyc_check("stall head");
    adv();
    credit_all_i[3*P_EAST +: 3] = 3'd0;
    flit(P_WEST, P_EAST, 0, 0);
    for (int k = 0; k < 3; k++) begin
      cyc_check("stall");
      chk("stall no send", 32'(send_o), 32'd0);
      chk("stall no dec", 32'(credit_dec_o), 32'd0);
      adv();
    end
    credit_all_i[3*P_EAST +: 3] = 3'd1;
    cyc_check("stall resume");
    chk("stall resume send", 32'(send_o), 32'b00100);
    chk("stall resume dec", 32'(credit_dec_o), 32'b01000);
    adv();
    credit_all_i = {5{3'd7}};
    flit(P_WEST, P_EAST, 0, 1);
    cyc_check("stall tail");
    adv();
    clear_in();

    // Watchdog: owner goes silent after its head.
    flit(1, P_NORTH, 1, 0);
    cyc_check("wd head");
    adv();
    clear_in();
    flit(3, P_NORTH, 1, 1);
    for (int k = 0; k < TIMEOUT; k++) begin
      cyc_check("wd idle");
      chk("wd no pulse", 32'(timeout_o), 32'd0);
      chk("wd waiter blocked", 32'(send_o), 32'd0);
      adv();
    end
    cyc_check("wd fire");
    chk("wd pulse", 32'(timeout_o), 32'b10000);
    chk("wd waiter granted", 32'(send_o), 32'b01000);
    chk("wd unlocked", 32'(locked_o[P_NORTH]), 32'd0);
    adv();
    clear_in();
    cyc_check("wd after");
    chk("wd pulse single", 32'(timeout_o), 32'd0);
    adv();

    // Multi-hot request sets the sticky error.
    chk("err clear before", 32'(error_o), 32'd0);
    slice = 5'b00110;
    req_i[4:0] = slice;
    head_i[0] = 1'b1; tail_i[0] = 1'b1;
    cyc_check("multihot");
    chk("multihot no send", 32'(send_o), 32'd0);
    adv();
    clear_in();
    cyc_check("multihot after");
    chk("multihot error", 32'(error_o), 32'd1);
    adv();

    // Asynchronous reset in the middle of a packet.
    flit(4, P_SOUTH, 1, 0);
    cyc_check("rst head");
    adv();
    flit(4, P_SOUTH, 0, 0);
    #2 rst = 1'b1;
    #1;
    chk("rst sel", 32'(sel_o), 32'h7fff);
    chk("rst send", 32'(send_o), 32'd0);
    chk("rst dec", 32'(credit_dec_o), 32'd0);
    chk("rst locked", 32'(locked_o), 32'd0);
    chk("rst error", 32'(error_o), 32'd0);
    chk("rst timeout", 32'(timeout_o), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    clear_in();
    cyc_check("post rst");
    adv();

    // Random traffic against the model.
    for (int c = 0; c < 400; c++) begin
      clear_in();
      for (int i = 0; i < 5; i++) begin
        int r;
        r = int'($urandom_range(0, 19));
        if (r < 6) continue;
        if (r == 19 && $urandom_range(0, 9) == 0) req_i[5*i +: 5] = 5'b00011 << $urandom_range(0, 3);
        else req_i[5*i +: 5] = 5'b00001 << $urandom_range(0, 4);
        head_i[i] = ($urandom_range(0, 2) == 0);
        tail_i[i] = ($urandom_range(0, 2) == 0);
      end
      for (int p = 0; p < 5; p++) credit_all_i[3*p +: 3] = 3'($urandom_range(0, 7));
      cyc_check("rand");
      adv();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
